cbd_stream_sampler: RTL and testbench

Streaming, parametrised centered-binomial sampler for the Kyber polynomial-sampling path. It consumes PRF output bytes over a valid/ready byte stream and emits the 256 coefficients of one polynomial over a valid/ready coefficient stream. `ETA` is selectable (2 or 3), so one block serves both secret/error sampling settings. It sits between the PRF/XOF byte source and the NTT/polynomial buffer.

---
 rtl/cbd_stream_sampler.sv | 193 +++++++++++++++++++
 tb/tb_cbd_stream_sampler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_stream_sampler.sv
// cbd_stream_sampler
//   Streaming centered-binomial (CBD) sampler for the Kyber polynomial path.
//   PRF bytes arrive on a valid/ready byte stream, are packed LSB first into a
//   small bit buffer, and every 2*ETA buffered bits become one coefficient
//   f = popcount(low ETA bits) - popcount(next ETA bits), in [-ETA, ETA].
//   Exactly 64*ETA bytes are consumed and N coefficients emitted per start.
//
//   Optional feature macro: CBD_MODQ_EN
//     defined   : out_coef = f mod 3329, unsigned in [0, 3328], zero-extended
//     undefined : out_coef = f, two's complement sign-extended to COEF_W
//
// Parameters: ETA (2 or 3), COEF_W (>= 12), N (coefficients per polynomial)
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      one-cycle request, ignored while busy
//   in_valid/in_data/in_ready  PRF byte stream (consumer side)
//   out_valid/out_ready        coefficient stream (producer side)
//   out_coef/out_idx/out_last  coefficient, its index, last-coefficient flag
//   busy                       polynomial in progress
//   done                       one-cycle pulse after the final coefficient handshake
module cbd_stream_sampler #(
  parameter int ETA    = 2,
  parameter int COEF_W = 12,
  parameter int N      = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [7:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // Buffer holds at most (2*ETA-1) leftover bits plus one fresh byte.
  localparam int         BW       = 2 * ETA + 7;
  localparam logic [3:0] TWO_ETA  = 4'(2 * ETA);
  localparam logic [7:0] N_BYTES  = 8'(64 * ETA);
  localparam logic [8:0] N_COEF   = 9'(N);
  localparam logic [8:0] LAST_IDX = 9'(N - 1);

  generate
    if (ETA != 2 && ETA != 3) begin : g_bad_eta
      $error("cbd_stream_sampler: ETA must be 2 or 3");
    end
    if (COEF_W < 12) begin : g_bad_coef_w
      $error("cbd_stream_sampler: COEF_W must be at least 12");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // f = popcount(bits[ETA-1:0]) - popcount(bits[2ETA-1:ETA]), 4-bit two's complement
  function automatic logic signed [3:0] cbd_diff(input logic [2*ETA-1:0] bits);
    logic [3:0] a;
    logic [3:0] b;
    a = 4'd0;
    b = 4'd0;
    for (int i = 0; i < ETA; i++) begin
      a = a + {3'b000, bits[i]};
      b = b + {3'b000, bits[ETA+i]};
    end
    return $signed(a - b);
  endfunction

  // Output encoding of one coefficient
  function automatic logic [COEF_W-1:0] encode(input logic signed [3:0] f);
`ifdef CBD_MODQ_EN
    int fi;
    fi = int'(f);
    if (fi < 32'sd0) begin
      fi = fi + 32'sd3329;
    end else begin
      fi = fi;
    end
    return COEF_W'(fi);
`else
    return {{(COEF_W-4){f[3]}}, f};
`endif
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [BW-1:0]     buf_r;
  logic [3:0]        bit_cnt_r;
  logic [7:0]        byte_cnt_r;
  logic [8:0]        coef_cnt_r;
  logic              run_s;
  logic              accept_s;
  logic              fire_s;
  logic              out_hs_s;
  logic              final_hs_s;

  // Handshake and coefficient-formation qualifiers derived from registered state
  always_comb begin
    run_s      = (state_r == S_RUN);
    in_ready   = run_s && (bit_cnt_r < TWO_ETA) && (byte_cnt_r < N_BYTES);
    accept_s   = in_valid && in_ready;
    out_hs_s   = out_valid && out_ready;
    final_hs_s = out_hs_s && out_last && run_s;
    // A new coefficient may only overwrite the output register once it is free.
    fire_s     = run_s && (bit_cnt_r >= TWO_ETA) && (coef_cnt_r < N_COEF) &&
                 (!out_valid || out_ready);
  end

  assign busy = (state_r == S_RUN);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (final_hs_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RUN;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bit buffer, counters and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_r      <= '0;
      bit_cnt_r  <= 4'd0;
      byte_cnt_r <= 8'd0;
      coef_cnt_r <= 9'd0;
      out_valid  <= 1'b0;
      out_coef   <= '0;
      out_idx    <= 8'd0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= final_hs_s;
      if ((state_r == S_IDLE) && start) begin
        buf_r      <= '0;
        bit_cnt_r  <= 4'd0;
        byte_cnt_r <= 8'd0;
        coef_cnt_r <= 9'd0;
      end else if (accept_s) begin
        // Bits above the occupancy are always zero, so OR appends the byte.
        buf_r      <= buf_r | (BW'(in_data) << bit_cnt_r);
        bit_cnt_r  <= bit_cnt_r + 4'd8;
        byte_cnt_r <= byte_cnt_r + 8'd1;
      end else if (fire_s) begin
        buf_r      <= buf_r >> TWO_ETA;
        bit_cnt_r  <= bit_cnt_r - TWO_ETA;
        coef_cnt_r <= coef_cnt_r + 9'd1;
      end else begin
        buf_r <= buf_r;
      end

      if (fire_s) begin
        out_valid <= 1'b1;
        out_coef  <= encode(cbd_diff(buf_r[2*ETA-1:0]));
        out_idx   <= coef_cnt_r[7:0];
        out_last  <= (coef_cnt_r == LAST_IDX);
      end else if (out_hs_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_cbd_stream_sampler.sv
// Testbench for cbd_stream_sampler: one ETA=2 and one ETA=3 instance, a
// bit-index reference model of the CBD stream, and a per-cycle compare process.
module tb_cbd_stream_sampler;

  logic        clk;
  logic        reset;
  logic        start0, in_valid0, in_ready0, out_valid0, out_ready0, out_last0, busy0, done0;
  logic [7:0]  in_data0, out_idx0;
  logic [11:0] out_coef0;
  logic        start1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1, done1;
  logic [7:0]  in_data1, out_idx1;
  logic [11:0] out_coef1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cbd_stream_sampler #(.ETA(2), .COEF_W(12), .N(256)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_coef(out_coef0),
    .out_idx(out_idx0), .out_last(out_last0), .busy(busy0), .done(done0)
  );

  cbd_stream_sampler #(.ETA(3), .COEF_W(12), .N(256)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_coef(out_coef1),
    .out_idx(out_idx1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

`ifdef CBD_MODQ_EN
  localparam logic [11:0] C_P2 = 12'd2;
  localparam logic [11:0] C_M2 = 12'd3327;
`else
  localparam logic [11:0] C_P2 = 12'h002;
  localparam logic [11:0] C_M2 = 12'hFFE;
`endif

  int vectors = 0;
  int miscompares = 0;

  byte unsigned mem [2][192];
  int   ptr [2];
  int   exp_idx [2];
  int   bytes_acc [2];
  logic prev_stall [2];
  logic pend_done [2];
  logic [11:0] prev_coef [2];
  logic [7:0]  prev_idx [2];
  logic        prev_last [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit pos of the lane's byte stream, LSB of byte 0 first.
  function automatic int bit_at(input int lane, input int pos);
    return int'((mem[lane][pos / 8] >> (pos % 8)) & 8'd1);
  endfunction

  // Coefficient k as an integer in [-eta, eta].
  function automatic int gold(input int lane, input int eta, input int k);
    int a = 0;
    int b = 0;
    for (int i = 0; i < eta; i++) begin
      a += bit_at(lane, 2 * eta * k + i);
      b += bit_at(lane, 2 * eta * k + eta + i);
    end
    return a - b;
  endfunction

  function automatic logic [11:0] enc(input int f);
`ifdef CBD_MODQ_EN
    return (f < 0) ? 12'(f + 3329) : 12'(f);
`else
    return 12'(f);
`endif
  endfunction

  task automatic lane_check(input int lane, input int eta, input logic ov, input logic orr,
                            input logic [11:0] coef, input logic [7:0] idx, input logic last,
                            input logic iv, input logic ir, input logic dn);
    if (reset) begin
      exp_idx[lane] = 0; bytes_acc[lane] = 0; prev_stall[lane] = 1'b0; pend_done[lane] = 1'b0;
      return;
    end
    chk($sformatf("L%0d done", lane), 32'(dn), 32'(pend_done[lane]));
    if (pend_done[lane]) begin
      chk($sformatf("L%0d bytes per poly", lane), bytes_acc[lane], 64 * eta);
      exp_idx[lane] = 0; bytes_acc[lane] = 0; pend_done[lane] = 1'b0;
    end
    if (prev_stall[lane]) begin
      chk($sformatf("L%0d stall valid", lane), 32'(ov), 32'd1);
      chk($sformatf("L%0d stall coef", lane), 32'(coef), 32'(prev_coef[lane]));
      chk($sformatf("L%0d stall idx", lane), 32'(idx), 32'(prev_idx[lane]));
      chk($sformatf("L%0d stall last", lane), 32'(last), 32'(prev_last[lane]));
    end
    if (iv && ir) begin
      bytes_acc[lane]++;
      chk($sformatf("L%0d byte overrun", lane), 32'(bytes_acc[lane] > 64 * eta), 32'd0);
    end
    if (ov && orr) begin
      if (exp_idx[lane] > 255) begin
        chk($sformatf("L%0d coef count", lane), exp_idx[lane], 255);
      end else begin
        chk($sformatf("L%0d coef[%0d]", lane, exp_idx[lane]), 32'(coef),
            32'(enc(gold(lane, eta, exp_idx[lane]))));
        chk($sformatf("L%0d idx", lane), 32'(idx), 32'(exp_idx[lane]));
        chk($sformatf("L%0d last", lane), 32'(last), 32'(exp_idx[lane] == 255));
        if (exp_idx[lane] == 255) pend_done[lane] = 1'b1;
      end
      exp_idx[lane]++;
    end
    prev_stall[lane] = ov && !orr;
    prev_coef[lane]  = coef;
    prev_idx[lane]   = idx;
    prev_last[lane]  = last;
  endtask

  // Compare process: both instances every cycle, sampled on the falling edge
  always @(negedge clk) begin
    lane_check(0, 2, out_valid0, out_ready0, out_coef0, out_idx0, out_last0, in_valid0, in_ready0, done0);
    lane_check(1, 3, out_valid1, out_ready1, out_coef1, out_idx1, out_last1, in_valid1, in_ready1, done1);
  end

  task automatic set_lane(input int lane, input logic st, input logic iv, input logic orr);
    int p;
    p = (ptr[lane] < 192) ? ptr[lane] : 191;
    if (lane == 0) begin
      start0 = st; in_valid0 = iv; out_ready0 = orr; in_data0 = mem[0][p];
    end else begin
      start1 = st; in_valid1 = iv; out_ready1 = orr; in_data1 = mem[1][p];
    end
  endtask

  // mode 0: both held 1; 1: random stalls; 2: out_ready held 0; 3: out_ready 1 once
  task automatic drive(input int lane, input int mode, input logic st);
    logic iv;
    logic orr;
    iv  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    orr = (mode == 1) ? ($urandom_range(0, 2) != 0) : (mode != 2);
    set_lane(lane, st, iv, orr);
  endtask

  task automatic step(input int lane, input int mode, input logic st, output logic dn);
    logic acc;
    @(negedge clk);
    acc = (lane == 0) ? (in_valid0 && in_ready0) : (in_valid1 && in_ready1);
    dn  = (lane == 0) ? done0 : done1;
    @(posedge clk); #1;
    if (acc) ptr[lane]++;
    drive(lane, mode, st);
  endtask

  task automatic begin_poly(input int lane, input int mode);
    ptr[lane] = 0;
    @(posedge clk); #1;
    drive(lane, mode, 1'b1);
    @(posedge clk); #1;
    drive(lane, mode, 1'b0);
  endtask

  // Steps until done (or out_idx == stop_idx); returns steps taken
  task automatic run_loop(input int lane, input int mode, input int pulse_at,
                          input int stop_idx, output int cycles);
    logic dn;
    logic fin;
    fin = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 6000 && !fin; c++) begin
      step(lane, mode, (c == pulse_at), dn);
      cycles = c;
      if (dn) fin = 1'b1;
      if (stop_idx >= 0 && out_valid0 && out_idx0 == 8'(stop_idx)) fin = 1'b1;
    end
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL L%0d timeout: no done after %0d cycles", lane, cycles);
    end
    set_lane(lane, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int lane, input logic rnd);
    for (int i = 0; i < 192; i++) mem[lane][i] = rnd ? 8'($urandom_range(0, 255)) : 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready0"}, 32'(in_ready0), 32'd0);
    chk({tag, " out_valid0"}, 32'(out_valid0), 32'd0);
    chk({tag, " out_coef0"}, 32'(out_coef0), 32'd0);
    chk({tag, " out_idx0"}, 32'(out_idx0), 32'd0);
    chk({tag, " out_last0"}, 32'(out_last0), 32'd0);
    chk({tag, " busy0"}, 32'(busy0), 32'd0);
    chk({tag, " done0"}, 32'(done0), 32'd0);
    chk({tag, " busy1"}, 32'(busy1), 32'd0);
    chk({tag, " out_valid1"}, 32'(out_valid1), 32'd0);
  endtask

  initial begin
    int   cyc;
    logic dn;
    ptr[0] = 0; ptr[1] = 0;
    fill(0, 1'b0); fill(1, 1'b0);
    reset = 1'b1;
    set_lane(0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // All-zero bytes, no stalls: 256 zeros, 3 cycles per byte
    fill(0, 1'b0);
    begin_poly(0, 0);
    chk("start busy0", 32'(busy0), 32'd1);
    chk("start in_ready0", 32'(in_ready0), 32'd1);
    run_loop(0, 0, 0, -1, cyc);
    chk("eta2 cycles to done", cyc, 386);

    // First byte 0xC3: coef0 = 2, coef1 = -2
    fill(0, 1'b1);
    mem[0][0] = 8'hC3;
    chk("pin gold c0", gold(0, 2, 0), 2);
    chk("pin gold c1", gold(0, 2, 1), -2);
    begin_poly(0, 2);
    for (int i = 0; i < 20 && !out_valid0; i++) step(0, 2, 1'b0, dn);
    chk("C3 coef0", 32'(out_coef0), 32'(C_P2));
    chk("C3 idx0", 32'(out_idx0), 32'd0);
    step(0, 3, 1'b0, dn);
    step(0, 2, 1'b0, dn);
    chk("C3 coef1", 32'(out_coef1 & 12'h000) | 32'(out_coef0), 32'(C_M2));
    chk("C3 idx1", 32'(out_idx0), 32'd1);
    run_loop(0, 1, 0, -1, cyc);

    // ETA=3: 0x38,0,0 -> -3,0,0,0; exactly 192 bytes
    fill(1, 1'b0);
    mem[1][0] = 8'h38;
    chk("pin gold eta3 c0", gold(1, 3, 0), -3);
    chk("pin gold eta3 c1", gold(1, 3, 1), 0);
    begin_poly(1, 0);
    run_loop(1, 0, 0, -1, cyc);
    chk("eta3 cycles to done", cyc, 450);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1'b0, dn);
      chk("eta3 in_ready after poly", 32'(in_ready1), 32'd0);
    end
    set_lane(1, 1'b0, 1'b0, 1'b0);

    // Random stalls, with a start pulse while busy (must be ignored)
    fill(0, 1'b1);
    begin_poly(0, 1);
    run_loop(0, 1, 40, -1, cyc);
    fill(1, 1'b1);
    begin_poly(1, 1);
    run_loop(1, 1, 0, -1, cyc);

    // Reset at coefficient 100, then a fresh polynomial from index 0
    fill(0, 1'b1);
    begin_poly(0, 1);
    run_loop(0, 1, 0, 100, cyc);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("mid reset");
    reset = 1'b0;
    fill(0, 1'b1);
    begin_poly(0, 1);
    run_loop(0, 1, 0, -1, cyc);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
